// File: rtl/multicycle_control_hs.sv
// Multicycle RV32I control FSM with memory ready handshake, wait-state watchdog
// and sticky error reporting; drives every datapath enable and mux select.
module multicycle_control_hs #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TIMEOUT_W   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_write,
    output logic       reg_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       instruction_or_data,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] imm_src,
    output logic [3:0] current_state,
    output logic       illegal_instr,
    output logic       mem_timeout
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_ERROR    = 4'd15
    } state_e;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam bit                   WD_EN   = (MEM_TIMEOUT > 0);
    localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_e               state_q, state_d;
    logic [TIMEOUT_W-1:0] wait_q, wait_d;
    logic                 illegal_q, illegal_d;
    logic                 timeout_q, timeout_d;
    logic                 mem_write_c, reg_write_c, ir_write_c, pc_write_c;
    logic [2:0]           alu_i_op, alu_r_op;
    logic                 wait_state, wd_expire;
    logic                 unused_funct7;

    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        case (funct3)
            3'b111:  alu_i_op = ALU_AND;
            3'b110:  alu_i_op = ALU_OR;
            3'b010:  alu_i_op = ALU_SLT;
            default: alu_i_op = ALU_ADD;
        endcase
        alu_r_op = (funct3 == 3'b000 && funct7[5]) ? ALU_SUB : alu_i_op;
    end

    assign wait_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
    assign wd_expire  = WD_EN && wait_state && !mem_ready && (wait_q == WD_LAST);

    // NOTE: every output of this block gets a default before the case, so no
    // path through it can leave a value unassigned and infer a latch.
    always_comb begin
        state_d             = state_q;
        illegal_d           = illegal_q;
        timeout_d           = timeout_q;
        wait_d              = '0;
        mem_write_c         = 1'b0;
        reg_write_c         = 1'b0;
        ir_write_c          = 1'b0;
        pc_write_c          = 1'b0;
        instruction_or_data = 1'b0;
        result_src          = 2'b00;
        alu_src_a           = 2'b00;
        alu_src_b           = 2'b00;
        alu_control         = ALU_ADD;
        imm_src             = 2'b00;

        case (state_q)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    OP_LW:   state_d = S_MEMADR;
                    OP_SW:   begin imm_src = 2'b01; state_d = S_MEMADR; end
                    OP_R:    state_d = S_EXECUTER;
                    OP_I:    state_d = S_EXECUTEI;
                    OP_BEQ:  begin imm_src = 2'b10; state_d = S_BEQ; end
                    OP_JAL:  begin imm_src = 2'b11; state_d = S_JAL; end
                    default: begin state_d = S_ERROR; illegal_d = 1'b1; end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                if (opcode == OP_SW) begin
                    imm_src = 2'b01;
                    state_d = S_MEMWRITE;
                end else begin
                    state_d = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                instruction_or_data = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src  = 2'b01;
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWRITE: begin
                instruction_or_data = 1'b1;
                mem_write_c         = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECUTER: begin
                alu_src_a   = 2'b10;
                alu_control = alu_r_op;
                state_d     = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = alu_i_op;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_write_c = 1'b1;
                state_d    = S_ALUWB;
            end
            S_BEQ: begin
                alu_src_a   = 2'b10;
                alu_control = ALU_SUB;
                pc_write_c  = zero;
                state_d     = S_FETCH;
            end
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_ERROR;
        endcase

        // A ready response in the final allowed cycle wins over the watchdog.
        if (wait_state && !mem_ready && !wd_expire) wait_d = wait_q + 1'b1;
        if (wd_expire) begin
            state_d   = S_ERROR;
            timeout_d = 1'b1;
        end
    end

    assign mem_write     = mem_write_c & ~reset;
    assign reg_write     = reg_write_c & ~reset;
    assign ir_write      = ir_write_c  & ~reset;
    assign pc_write      = pc_write_c  & ~reset;
    assign current_state = state_q;
    assign illegal_instr = illegal_q;
    assign mem_timeout   = timeout_q;

endmodule

// File: tb/tb_multicycle_control_hs.sv
// Self-checking bench for multicycle_control_hs: directed plan items followed by
// random instruction streams checked against an instruction-level model.
module tb_multicycle_control_hs;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       zero;
    logic       mem_ready;
    logic       mem_write, reg_write, ir_write, pc_write, instruction_or_data;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    logic [3:0] current_state;
    logic       illegal_instr, mem_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_control_hs dut (
        .clk                (clk),
        .reset              (reset),
        .opcode             (opcode),
        .funct3             (funct3),
        .funct7             (funct7),
        .zero               (zero),
        .mem_ready          (mem_ready),
        .mem_write          (mem_write),
        .reg_write          (reg_write),
        .ir_write           (ir_write),
        .pc_write           (pc_write),
        .instruction_or_data(instruction_or_data),
        .result_src         (result_src),
        .alu_src_a          (alu_src_a),
        .alu_src_b          (alu_src_b),
        .alu_control        (alu_control),
        .imm_src            (imm_src),
        .current_state      (current_state),
        .illegal_instr      (illegal_instr),
        .mem_timeout        (mem_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic no_enables(input string tag);
        check({tag, "_wen"}, {mem_write, reg_write, ir_write, pc_write}, 4'b0000);
    endtask

    task automatic set_instr(input logic [31:0] instr);
        opcode = instr[6:0];
        funct3 = instr[14:12];
        funct7 = instr[31:25];
    endtask

    // Reference ALU operation straight from the funct3/funct7 table.
    function automatic logic [2:0] ref_alu(input logic [2:0] f3, input logic sub_ok);
        case (f3)
            3'b000:  return sub_ok ? 3'b001 : 3'b000;
            3'b111:  return 3'b010;
            3'b110:  return 3'b011;
            3'b010:  return 3'b101;
            default: return 3'b000;
        endcase
    endfunction

    task automatic do_reset();
        reset     = 1'b1;
        mem_ready = 1'b1;
        #1;
        no_enables("rst_high");
        tick();
        reset = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("rst_state", current_state, 0);
        check("rst_flags", {illegal_instr, mem_timeout}, 2'b00);
    endtask

    // Runs one instruction from FETCH back to FETCH (or into ERROR for an
    // unsupported opcode), with fw fetch wait cycles and mw data wait cycles.
    task automatic run_instr(input logic [31:0] instr, input int fw, input int mw, input logic zv);
        logic [6:0] op;
        logic [1:0] exp_imm;
        op = instr[6:0];
        set_instr(instr);
        zero = zv;
        case (op)
            7'b0100011: exp_imm = 2'b01;
            7'b1100011: exp_imm = 2'b10;
            7'b1101111: exp_imm = 2'b11;
            default:    exp_imm = 2'b00;
        endcase

        for (int i = 0; i <= fw; i++) begin
            mem_ready = (i == fw);
            #1;
            check("fetch_state", current_state, 0);
            check("fetch_irpc", {ir_write, pc_write}, (i == fw) ? 2'b11 : 2'b00);
            check("fetch_sel", {instruction_or_data, alu_src_a, alu_src_b, result_src, alu_control},
                  {1'b0, 2'b00, 2'b10, 2'b10, 3'b000});
            tick();
        end

        mem_ready = 1'($urandom);
        #1;
        check("dec_state", current_state, 1);
        check("dec_sel", {alu_src_a, alu_src_b, alu_control}, {2'b01, 2'b01, 3'b000});
        check("dec_imm", imm_src, exp_imm);
        no_enables("dec");
        tick();

        case (op)
            7'b0000011, 7'b0100011: begin
                check("madr_state", current_state, 2);
                check("madr_sel", {alu_src_a, alu_src_b, alu_control}, {2'b10, 2'b01, 3'b000});
                check("madr_imm", imm_src, (op == 7'b0100011) ? 2'b01 : 2'b00);
                tick();
                for (int i = 0; i <= mw; i++) begin
                    mem_ready = (i == mw);
                    #1;
                    check("mem_state", current_state, (op == 7'b0100011) ? 5 : 3);
                    check("mem_iord", instruction_or_data, 1);
                    check("mem_we", mem_write, (op == 7'b0100011));
                    tick();
                end
                if (op == 7'b0000011) begin
                    check("mwb_state", current_state, 4);
                    check("mwb_out", {reg_write, result_src}, {1'b1, 2'b01});
                    tick();
                end
            end
            7'b0110011, 7'b0010011: begin
                check("ex_state", current_state, (op == 7'b0110011) ? 6 : 8);
                check("ex_sel", {alu_src_a, alu_src_b}, {2'b10, (op == 7'b0110011) ? 2'b00 : 2'b01});
                check("ex_alu", alu_control, ref_alu(instr[14:12], (op == 7'b0110011) && instr[30]));
                no_enables("ex");
                tick();
                check("aluwb_state", current_state, 7);
                check("aluwb_out", {reg_write, result_src}, {1'b1, 2'b00});
                tick();
            end
            7'b1100011: begin
                check("beq_state", current_state, 10);
                check("beq_sel", {alu_src_a, alu_src_b, alu_control}, {2'b10, 2'b00, 3'b001});
                check("beq_pcw", pc_write, zv);
                tick();
            end
            7'b1101111: begin
                check("jal_state", current_state, 9);
                check("jal_sel", {alu_src_a, alu_src_b, result_src, pc_write}, {2'b01, 2'b10, 2'b00, 1'b1});
                tick();
                check("jwb_state", current_state, 7);
                check("jwb_out", reg_write, 1);
                tick();
            end
            default: begin
                check("ill_state", current_state, 15);
                check("ill_flag", {illegal_instr, mem_timeout}, 2'b10);
                no_enables("ill");
                return;
            end
        endcase
        mem_ready = 1'b0;
        #1;
        check("back_fetch", current_state, 0);
    endtask

    function automatic logic [31:0] rand_instr(input int cls);
        logic [31:0] r;
        logic [6:0]  ops [6];
        logic [6:0]  bad [6];
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
        bad = '{7'h7F, 7'h00, 7'h37, 7'h17, 7'h67, 7'h73};
        r = $urandom;
        r[6:0] = (cls < 6) ? ops[cls] : bad[$urandom_range(0, 5)];
        return r;
    endfunction

    initial begin
        reset = 1'b1;
        mem_ready = 1'b0;
        zero = 1'b0;
        set_instr(32'h0);
        do_reset();

        // Directed plan items.
        run_instr(32'h00412083, 0, 0, 1'b0);   // lw
        run_instr(32'h00112223, 3, 2, 1'b0);   // sw, fetch waits 3, store waits 2
        run_instr(32'h402081B3, 0, 0, 1'b0);   // sub
        run_instr(32'h0020F1B3, 0, 0, 1'b0);   // and
        run_instr(32'h00208463, 0, 0, 1'b1);   // beq taken
        run_instr(32'h00208463, 0, 0, 1'b0);   // beq not taken
        run_instr(32'h008000EF, 0, 0, 1'b0);   // jal
        run_instr(32'h00412083, 14, 14, 1'b0); // ready on the last allowed cycle wins

        run_instr(32'h0000007F, 0, 0, 1'b0);
        mem_ready = 1'b1;
        tick();
        check("err_stays", current_state, 15);
        no_enables("err_hold");
        do_reset();

        // Watchdog in FETCH: exactly 15 not-ready cycles.
        mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            #1;
            check("wd_fetch_state", current_state, 0);
            tick();
        end
        check("wd_err_state", current_state, 15);
        check("wd_flags", {illegal_instr, mem_timeout}, 2'b01);
        do_reset();

        // Watchdog in MEMREAD, then reset while mid-wait in MEMREAD.
        for (int pass = 0; pass < 2; pass++) begin
            set_instr(32'h00412083);
            mem_ready = 1'b1;
            tick();
            tick();
            tick();
            mem_ready = 1'b0;
            for (int i = 0; i < ((pass == 0) ? 15 : 6); i++) begin
                #1;
                check("wd_mrd_state", current_state, 3);
                tick();
            end
            if (pass == 0) begin
                check("wd_mrd_err", {current_state, mem_timeout}, {4'd15, 1'b1});
            end
            do_reset();
        end
        // Counter must have been cleared by reset: 14 waits still succeed.
        run_instr(32'h00112223, 14, 0, 1'b0);

        // Random instruction stream against the instruction-level model.
        for (int n = 0; n < 60; n++) begin
            int cls;
            int fw;
            int mw;
            cls = $urandom_range(0, 6);
            fw  = ($urandom_range(0, 7) == 0) ? 14 : $urandom_range(0, 3);
            mw  = ($urandom_range(0, 7) == 0) ? 14 : $urandom_range(0, 3);
            run_instr(rand_instr(cls), fw, mw, 1'($urandom));
            if (cls == 6) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control_hs.md
Name: multicycle_control_hs

Overview:
- Parametrised successor to the multicycle RV32I control FSM.
- Adds a memory ready/wait-state handshake, a watchdog timeout, beq/jal sequencing, imm_src generation, and a sticky error state.
- Sits beside the datapath and drives every datapath enable and mux select from the instruction fields and the datapath zero flag.

Parameters:
- MEM_TIMEOUT, 15: consecutive not-ready cycles in a memory-wait state before entering ERROR; 0 disables the watchdog.
- TIMEOUT_W, 4: width of the wait counter; must satisfy MEM_TIMEOUT < 2**TIMEOUT_W.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  7  instr[6:0].
- funct3  in  3  instr[14:12].
- funct7  in  7  instr[31:25].
- zero  in  1  ALU zero flag from the datapath.
- mem_ready  in  1  memory has completed the current access this cycle.
- mem_write  out  1  data memory write enable.
- reg_write  out  1  register file write enable.
- ir_write  out  1  instruction register / old-PC load.
- pc_write  out  1  PC load.
- instruction_or_data  out  1  memory address select: 0 = PC, 1 = ALUOut.
- result_src  out  2  result select: 00 = ALUOut, 01 = read data, 10 = ALU result.
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = old PC, 10 = rs1.
- alu_src_b  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = constant 4.
- alu_control  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- imm_src  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- current_state  out  4  state encoding, for debug.
- illegal_instr  out  1  sticky: an unsupported opcode was decoded.
- mem_timeout  out  1  sticky: the watchdog expired.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BEQ=10, ERROR=15.
- Reset: state=FETCH, wait counter=0, illegal_instr=0, mem_timeout=0.
- While reset is high, all write enables are 0. Reset overrides every state, including ERROR and mid-wait.
- Outputs are combinational from the state, plus mem_ready and zero where stated below. Any unlisted select is 00. alu_control is add unless stated.
- FETCH:
  - instruction_or_data=0, alu_src_a=00, alu_src_b=10, add, result_src=10.
  - ir_write=pc_write=1 only in a cycle where mem_ready=1; on that edge go to DECODE. Otherwise stay in FETCH.
- DECODE:
  - alu_src_a=01, alu_src_b=01, add (branch target into ALUOut).
  - imm_src from opcode: lw/I-type=00, sw=01, beq=10, jal=11.
  - Next state by opcode: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BEQ; 1101111 -> JAL.
  - Any other opcode -> ERROR and set illegal_instr.
- MEMADR: alu_src_a=10, alu_src_b=01, add; imm_src=00 for lw, 01 for sw. lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD: instruction_or_data=1. Go to MEMWB when mem_ready=1; otherwise wait.
- MEMWB: result_src=01, reg_write=1 -> FETCH.
- MEMWRITE: instruction_or_data=1, mem_write=1 held for every wait cycle. Go to FETCH when mem_ready=1.
- EXECUTER: alu_src_a=10, alu_src_b=00 -> ALUWB. alu_control is decoded as follows:
  - funct3 000: sub if funct7[5]=1, else add.
  - funct3 111: and.
  - funct3 110: or.
  - funct3 010: slt.
  - Other funct3: add.
- EXECUTEI: alu_src_a=10, alu_src_b=01, imm_src=00 -> ALUWB. Same decode as EXECUTER, but funct7 is ignored (never sub).
- ALUWB: result_src=00, reg_write=1 -> FETCH.
- JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1 (PC <- target) -> ALUWB (rd <- old PC+4).
- BEQ: alu_src_a=10, alu_src_b=00, sub, result_src=00, pc_write=zero -> FETCH.
- ERROR: all enables 0; remain in ERROR until reset. Both sticky flags clear only on reset.
- Watchdog (applies in FETCH, MEMREAD, MEMWRITE):
  - The counter increments on each cycle with mem_ready=0.
  - It clears when mem_ready=1 or on leaving the state.
  - If MEM_TIMEOUT>0, the counter equals MEM_TIMEOUT-1 and mem_ready=0, the next state is ERROR and mem_timeout is set.
  - ERROR is therefore entered after exactly MEM_TIMEOUT consecutive not-ready cycles.
  - If mem_ready=1 in that same cycle, the ready response wins.

Test Plan:
- lw x1,4(x2) (0x00412083), mem_ready=1 -> current_state sequence 0,1,2,3,4,0. State 4 shows reg_write=1, result_src=01. State 2 shows alu_src_b=01.
- FETCH with mem_ready low for 3 cycles, then high -> state stays 0 for 4 cycles. ir_write and pc_write are high only in the 4th cycle. DECODE follows.
- sw (0x00112223) with mem_ready low for 2 cycles in MEMWRITE -> mem_write=1 for 3 cycles, instruction_or_data=1, then FETCH.
- sub x3,x1,x2 (0x402081B3) -> EXECUTER with alu_control=001, then ALUWB with reg_write=1. Repeat with and (funct3 111) -> alu_control=010.
- beq (0x00208463): zero=1 -> pc_write=1 in state 10; zero=0 -> pc_write=0. jal (0x008000EF) -> states 1,9,7,0, imm_src=11 in DECODE.
- Error cases:
  - opcode 0x7F -> state 15, illegal_instr=1.
  - MEM_TIMEOUT=15 with mem_ready held 0 in FETCH -> state 15 after exactly 15 cycles, mem_timeout=1.
  - Reset pulse (in ERROR and mid-MEMREAD) -> state 0 and flags 0 on the next edge.
